ssp_rx_fifo_p: RTL and testbench

Parametrised receive FIFO for the SSP block. It buffers words from the receive shifter until the APB side reads them. Compared with the fixed 4x8 RxFIFO, it adds configurable width and depth, a fill-level output, an almost-full threshold, sticky overrun/underrun status and a synchronous flush. It sits between the receive shift logic (`rxdata`/`read_en`) and the APB read mux (`prdata`).

---
 rtl/ssp_rx_fifo_p.sv | 98 +++++++++
 tb/tb_ssp_rx_fifo_p.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssp_rx_fifo_p.sv
// SSP receive FIFO: parametrised width/depth, fill level, almost-full threshold,
// sticky overrun/underrun status and synchronous flush.
module ssp_rx_fifo_p #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned AF_THRESH  = DEPTH - 1,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  pclk,
    input  logic                  clr_b,
    input  logic                  psel,
    input  logic                  pwrite,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] rxdata,
    input  logic                  flush,
    input  logic                  ovr_clr,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  flag_empty,
    output logic                  flag_full,
    output logic                  flag_almost_full,
    output logic [AW:0]           level,
    output logic                  flag_overrun,
    output logic                  flag_underrun
);

    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] DepthLvl = PW'(DEPTH);
    localparam logic [PW-1:0] AfLvl    = PW'(AF_THRESH);
    localparam logic [PW-1:0] PtrOne   = PW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         w_ptr;
    logic [PW-1:0]         r_ptr;
    logic                  read_en_d;
    logic                  rd_acc_d;

    logic rd_acc;
    logic push_req;
    logic pop_req;
    logic do_push;
    logic do_pop;
    logic set_ovr;
    logic set_und;

    // Pointers carry a phase bit, so the modular difference is the fill level.
    assign level            = w_ptr - r_ptr;
    assign flag_empty       = (level == '0);
    assign flag_full        = (level == DepthLvl);
    assign flag_almost_full = (level >= AfLvl);

    assign rd_acc   = psel & ~pwrite;
    assign push_req = read_en & ~read_en_d;
    assign pop_req  = rd_acc & ~rd_acc_d;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = ~flush & push_req & (~flag_full | pop_req);
    assign do_pop  = ~flush & pop_req & ~flag_empty;
    assign set_ovr = ~flush & push_req & flag_full & ~pop_req;
    assign set_und = ~flush & pop_req & flag_empty;

    always_ff @(posedge pclk or negedge clr_b) begin
        if (!clr_b) begin
            w_ptr         <= '0;
            r_ptr         <= '0;
            read_en_d     <= 1'b0;
            rd_acc_d      <= 1'b0;
            prdata        <= '0;
            flag_overrun  <= 1'b0;
            flag_underrun <= 1'b0;
        end else begin
            read_en_d <= read_en;
            rd_acc_d  <= rd_acc;

            if (flush) begin
                w_ptr <= '0;
                r_ptr <= '0;
            end else begin
                if (do_push) w_ptr <= w_ptr + PtrOne;
                if (do_pop)  r_ptr <= r_ptr + PtrOne;
            end

            if (do_pop) begin
                prdata <= mem[r_ptr[AW-1:0]];
            end else if (set_und) begin
                prdata <= '0;
            end

            // Set wins over a same-cycle clear.
            flag_overrun  <= set_ovr | (flag_overrun & ~ovr_clr);
            flag_underrun <= set_und | (flag_underrun & ~ovr_clr);
        end
    end

    always_ff @(posedge pclk) begin
        if (do_push) mem[w_ptr[AW-1:0]] <= rxdata;
    end

endmodule

// File: tb/tb_ssp_rx_fifo_p.sv
// Self-checking bench for ssp_rx_fifo_p: directed table, corner-case sequences and
// randomized traffic checked against a queue-based reference model.
module tb_ssp_rx_fifo_p;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AFT   = 3;
    localparam int AW    = 2;

    logic          pclk = 1'b0;
    logic          clr_b = 1'b0;
    logic          psel = 1'b0;
    logic          pwrite = 1'b0;
    logic          read_en = 1'b0;
    logic [DW-1:0] rxdata = '0;
    logic          flush = 1'b0;
    logic          ovr_clr = 1'b0;
    logic [DW-1:0] prdata;
    logic          flag_empty;
    logic          flag_full;
    logic          flag_almost_full;
    logic [AW:0]   level;
    logic          flag_overrun;
    logic          flag_underrun;

    always #5 pclk = ~pclk;

    ssp_rx_fifo_p #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AF_THRESH (AFT)
    ) dut (
        .pclk            (pclk),
        .clr_b           (clr_b),
        .psel            (psel),
        .pwrite          (pwrite),
        .read_en         (read_en),
        .rxdata          (rxdata),
        .flush           (flush),
        .ovr_clr         (ovr_clr),
        .prdata          (prdata),
        .flag_empty      (flag_empty),
        .flag_full       (flag_full),
        .flag_almost_full(flag_almost_full),
        .level           (level),
        .flag_overrun    (flag_overrun),
        .flag_underrun   (flag_underrun)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of stored words plus sticky flags.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_prd;
    logic          m_ovr, m_und, prev_re, prev_acc;
    int            wcnt, rcnt;

    typedef struct {
        logic          re;
        logic [DW-1:0] d;
        logic          sel;
        logic [DW-1:0] e_prd;
        int            e_lvl;
        logic          e_ovr;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_prd    = '0;
        m_ovr    = 1'b0;
        m_und    = 1'b0;
        prev_re  = 1'b0;
        prev_acc = 1'b0;
        wcnt     = 0;
        rcnt     = 0;
    endtask

    task automatic model_edge();
        logic pr, po, so, su, acc;
        int   n;
        acc      = psel && !pwrite;
        pr       = read_en && !prev_re;
        po       = acc && !prev_acc;
        prev_re  = read_en;
        prev_acc = acc;
        so       = 1'b0;
        su       = 1'b0;
        if (flush) begin
            q.delete();
            wcnt = 0;
            rcnt = 0;
        end else begin
            n = q.size();
            if (po) begin
                if (n == 0) begin
                    m_prd = '0;
                    su    = 1'b1;
                end else begin
                    m_prd = q.pop_front();
                    rcnt  = (rcnt + 1) % (2 * DEPTH);
                end
            end
            if (pr) begin
                if (n < DEPTH || po) begin
                    q.push_back(rxdata);
                    wcnt = (wcnt + 1) % (2 * DEPTH);
                end else begin
                    so = 1'b1;
                end
            end
        end
        m_ovr = so | (m_ovr & !ovr_clr);
        m_und = su | (m_und & !ovr_clr);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".prdata"}, prdata, m_prd);
        chk({tag, ".level"}, level, q.size());
        chk({tag, ".empty"}, flag_empty, q.size() == 0);
        chk({tag, ".full"}, flag_full, q.size() == DEPTH);
        chk({tag, ".afull"}, flag_almost_full, q.size() >= AFT);
        chk({tag, ".overrun"}, flag_overrun, m_ovr);
        chk({tag, ".underrun"}, flag_underrun, m_und);
    endtask

    task automatic step(input logic re, input logic [DW-1:0] d, input logic sel, input logic wr,
                        input logic fl, input logic oc, input string tag);
        read_en = re;
        rxdata  = d;
        psel    = sel;
        pwrite  = wr;
        flush   = fl;
        ovr_clr = oc;
        @(posedge pclk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic push(input logic [DW-1:0] d, input string tag);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, tag);
        idle(tag);
    endtask

    task automatic pop(input string tag);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, tag);
        idle(tag);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".prdata"}, prdata, 0);
        chk({tag, ".level"}, level, 0);
        chk({tag, ".empty"}, flag_empty, 1);
        chk({tag, ".full"}, flag_full, 0);
        chk({tag, ".afull"}, flag_almost_full, 0);
        chk({tag, ".overrun"}, flag_overrun, 0);
        chk({tag, ".underrun"}, flag_underrun, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_tail[4];

        // Fill 0x11..0x44, drop 0x55, then drain four words.
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1, 1'b0};
        tbl[2]  = '{1'b1, 8'h22, 1'b0, 8'h00, 2, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 2, 1'b0};
        tbl[4]  = '{1'b1, 8'h33, 1'b0, 8'h00, 3, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 3, 1'b0};
        tbl[6]  = '{1'b1, 8'h44, 1'b0, 8'h00, 4, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 4, 1'b0};
        tbl[8]  = '{1'b1, 8'h55, 1'b0, 8'h00, 4, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'h00, 4, 1'b1};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 8'h11, 3, 1'b1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h11, 3, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 8'h22, 2, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h22, 2, 1'b1};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 8'h33, 1, 1'b1};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 8'h33, 1, 1'b1};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 8'h44, 0, 1'b1};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 8'h44, 0, 1'b1};

        model_reset();
        #2;
        chk_reset_outputs("reset");
        #10;
        clr_b = 1'b1;

        // Reset then read while empty.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, "rd_empty");
        chk("rd_empty.prdata", prdata, 0);
        chk("rd_empty.underrun", flag_underrun, 1);
        chk("rd_empty.level", level, 0);
        idle("rd_empty");
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "und_clr");
        chk("und_clr.underrun", flag_underrun, 0);

        // Table-driven fill / overflow / drain.
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].re, tbl[i].d, tbl[i].sel, 1'b0, 1'b0, 1'b0, "tbl");
            chk($sformatf("tbl%0d.prdata", i), prdata, tbl[i].e_prd);
            chk($sformatf("tbl%0d.level", i), level, tbl[i].e_lvl);
            chk($sformatf("tbl%0d.overrun", i), flag_overrun, tbl[i].e_ovr);
            chk($sformatf("tbl%0d.full", i), flag_full, tbl[i].e_lvl == DEPTH);
            chk($sformatf("tbl%0d.afull", i), flag_almost_full, tbl[i].e_lvl >= AFT);
            chk($sformatf("tbl%0d.empty", i), flag_empty, tbl[i].e_lvl == 0);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "ovr_clr");
        chk("ovr_clr.overrun", flag_overrun, 0);

        // Wrap-around: 10 push/pop pairs.
        for (int i = 0; i < 10; i++) begin
            push(DW'(i), "wrap");
            pop("wrap");
            chk($sformatf("wrap%0d.prdata", i), prdata, i);
        end
        chk("wrap.w_ptr", dut.w_ptr, wcnt);
        chk("wrap.r_ptr", dut.r_ptr, rcnt);
        chk("wrap.ptr_eq", dut.w_ptr == dut.r_ptr, 1);
        chk("wrap.empty", flag_empty, 1);

        // Simultaneous push and pop when full.
        for (int i = 0; i < 4; i++) push(8'hA0 + DW'(i), "full_fill");
        step(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b0, "pushpop");
        chk("pushpop.prdata", prdata, 8'hA0);
        chk("pushpop.level", level, 4);
        chk("pushpop.overrun", flag_overrun, 0);
        idle("pushpop");
        exp_tail = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
        for (int i = 0; i < 4; i++) begin
            pop("pushpop_drain");
            chk($sformatf("pushpop_drain%0d", i), prdata, exp_tail[i]);
        end

        // Held strobes pop/push exactly once.
        push(8'h01, "held");
        push(8'h02, "held");
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, "held_rd");
        chk("held_rd.level", level, 1);
        chk("held_rd.prdata", prdata, 8'h01);
        idle("held");
        for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + DW'(i), 1'b0, 1'b0, 1'b0, 1'b0, "held_wr");
        chk("held_wr.level", level, 2);
        idle("held");

        // Flush with 3 entries and a sticky overrun set.
        push(8'hD0, "pre_flush");
        push(8'hD1, "pre_flush");
        push(8'hD2, "pre_flush");
        pop("pre_flush");
        chk("pre_flush.level", level, 3);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0, "flush");
        chk("flush.level", level, 0);
        chk("flush.empty", flag_empty, 1);
        chk("flush.overrun", flag_overrun, 1);
        chk("flush.prdata", prdata, 8'h02);
        idle("flush");
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "flush_clr");

        // Asynchronous reset between edges, with read_en high across release.
        push(8'h77, "pre_rst");
        pop("pre_rst");
        push(8'h78, "pre_rst");
        #3;
        clr_b = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        read_en = 1'b1;
        rxdata  = 8'h5A;
        #2;
        clr_b = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, "rst_exit");
        chk("rst_exit.level", level, 1);
        idle("rst_exit");
        pop("rst_exit");
        chk("rst_exit.prdata", prdata, 8'h5A);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic fl, oc;
            fl = ($urandom_range(0, 40) == 0);
            oc = !fl && ($urandom_range(0, 20) == 0);
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 9) < 4),
                 1'($urandom_range(0, 9) < 2), fl, oc, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
